// File: rtl/req_encoder.sv
// req_encoder: 32-to-5 sequential request encoder with sticky pending flags and valid/ready output. Rev 1.0
// Optional round-robin selection when REQ_ENC_RR_EN is defined; fixed lowest-index priority otherwise.
`default_nettype none

module req_encoder #(
  parameter int N     = 32,
  parameter int IDX_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     pending,
  output logic [IDX_W:0]   pending_cnt
);

  logic         handshake;
  logic [N-1:0] accept_mask;

  assign out_valid   = |pending;
  assign handshake   = out_valid & out_ready;
  assign accept_mask = handshake ? (N'(1) << out_idx) : '0;

`ifdef REQ_ENC_RR_EN
  logic [IDX_W-1:0] ptr;
  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;

  // Rotate so that bit ptr lands at position 0; lowest set bit of rot is the first at/after ptr.
  always_comb begin
    dbl = {pending, pending} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    out_idx = out_valid ? IDX_W'(ptr + off) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (handshake && !flush) begin
      ptr <= IDX_W'(out_idx + 1'b1);
    end
  end
`else
  always_comb begin
    out_idx = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (pending[i]) out_idx = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < N; i++) begin
      pending_cnt = pending_cnt + (IDX_W+1)'(pending[i]);
    end
  end

  // New requests are OR-ed in after the clear, so a set always wins over an accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else if (flush) begin
      pending <= req;
    end else begin
      pending <= (pending & ~accept_mask) | req;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_req_encoder.sv
// tb_req_encoder: table-driven directed checks for req_encoder, plus hand sequences for idle and round-robin.
`default_nettype none

module tb_req_encoder;

  logic        clock;
  logic        reset;
  logic [31:0] req;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic [31:0] pending;
  logic [5:0]  pending_cnt;

  int checks = 0;
  int errors = 0;

  req_encoder #(.N(32), .IDX_W(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .flush       (flush),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .pending     (pending),
    .pending_cnt (pending_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [31:0] rq;
    logic        fl;
    logic        rdy;
    logic        v;
    logic [4:0]  idx;
    logic [31:0] p;
    logic [5:0]  cnt;
  } vec_t;

  task automatic step(input logic r, input logic [31:0] rq, input logic fl, input logic rdy);
    reset     = r;
    req       = rq;
    flush     = fl;
    out_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic v, input logic [4:0] idx,
                       input logic [31:0] p, input logic [5:0] cnt);
    checks++;
    if (out_valid !== v || out_idx !== idx || pending !== p || pending_cnt !== cnt) begin
      errors++;
      $display("FAIL %s: got valid=%0b idx=%0d pending=%h cnt=%0d, expected valid=%0b idx=%0d pending=%h cnt=%0d",
               name, out_valid, out_idx, pending, pending_cnt, v, idx, p, cnt);
    end
  endtask

`ifndef REQ_ENC_RR_EN
  vec_t tbl[19];
  initial begin
    tbl[0]  = '{1'b0, 32'h8000_0011, 1'b0, 1'b0, 1'b1, 5'd0,  32'h8000_0011, 6'd3};
    tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 5'd4,  32'h8000_0010, 6'd2};
    tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 5'd31, 32'h8000_0000, 6'd1};
    tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         6'd0};
    tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         6'd0};
    tbl[5]  = '{1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 5'd2,  32'h0000_0004, 6'd1};
    tbl[6]  = '{1'b0, 32'h0000_0004, 1'b0, 1'b1, 1'b1, 5'd2,  32'h0000_0004, 6'd1};
    tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 5'd2,  32'h0000_0004, 6'd1};
    tbl[8]  = '{1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0000_0005, 6'd2};
    tbl[9]  = '{1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 6'd32};
    tbl[10] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 5'd0,  32'hFFFF_FFFF, 6'd32};
    tbl[11] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 5'd1,  32'hFFFF_FFFE, 6'd31};
    tbl[12] = '{1'b0, 32'h0000_0100, 1'b1, 1'b1, 1'b1, 5'd8,  32'h0000_0100, 6'd1};
    tbl[13] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         6'd0};
    tbl[14] = '{1'b0, 32'h00F0_0000, 1'b0, 1'b0, 1'b1, 5'd20, 32'h00F0_0000, 6'd4};
    tbl[15] = '{1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         6'd0};
    tbl[16] = '{1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0000_0003, 6'd2};
    tbl[17] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 5'd1,  32'h0000_0002, 6'd1};
    tbl[18] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         6'd0};
  end
`endif

  initial begin
    reset = 1'b1; req = '0; flush = 1'b0; out_ready = 1'b0;
    step(1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 1'b0, 1'b0);
    check("reset_state", 1'b0, 5'd0, 32'h0, 6'd0);

    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      check($sformatf("idle_%0d", i), 1'b0, 5'd0, 32'h0, 6'd0);
    end

`ifndef REQ_ENC_RR_EN
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].rq, tbl[i].fl, tbl[i].rdy);
      check($sformatf("vec_%0d", i), tbl[i].v, tbl[i].idx, tbl[i].p, tbl[i].cnt);
    end
`else
    step(1'b0, 32'h0000_0009, 1'b0, 1'b0);
    check("rr_load9", 1'b1, 5'd0, 32'h0000_0009, 6'd2);
    step(1'b0, 32'h0000_0001, 1'b0, 1'b1);
    check("rr_acc0_sel3", 1'b1, 5'd3, 32'h0000_0009, 6'd2);
    step(1'b0, 32'h0000_0001, 1'b0, 1'b1);
    check("rr_acc3_sel0", 1'b1, 5'd0, 32'h0000_0001, 6'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("rr_drain", 1'b0, 5'd0, 32'h0, 6'd0);
    step(1'b0, 32'h8000_0000, 1'b0, 1'b0);
    check("rr_load31", 1'b1, 5'd31, 32'h8000_0000, 6'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("rr_acc31", 1'b0, 5'd0, 32'h0, 6'd0);
    step(1'b0, 32'h0000_0003, 1'b0, 1'b0);
    check("rr_wrap_ptr0", 1'b1, 5'd0, 32'h0000_0003, 6'd2);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("rr_acc0_ptr1", 1'b1, 5'd1, 32'h0000_0002, 6'd1);
    step(1'b0, 32'h0000_0104, 1'b0, 1'b0);
    check("rr_hold", 1'b1, 5'd1, 32'h0000_0106, 6'd3);
    step(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("rr_full", 1'b1, 5'd1, 32'hFFFF_FFFF, 6'd32);
    step(1'b0, 32'h0000_0100, 1'b1, 1'b1);
    check("rr_flush", 1'b1, 5'd8, 32'h0000_0100, 6'd1);
    step(1'b0, 32'h00F0_0000, 1'b0, 1'b0);
    check("rr_load_f0", 1'b1, 5'd8, 32'h00F0_0100, 6'd5);
    step(1'b1, 32'h0, 1'b0, 1'b1);
    check("rr_mid_reset", 1'b0, 5'd0, 32'h0, 6'd0);
    step(1'b0, 32'h0000_0003, 1'b0, 1'b0);
    check("rr_ptr_reset", 1'b1, 5'd0, 32'h0000_0003, 6'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/req_encoder.md
Name: req_encoder

Overview:
- Sequential 32-to-5 request encoder. It is the return path that pairs with the 5-to-32 register and enable decode.
- Collects single-cycle request pulses from up to 32 sources into a pending register.
- Emits one 5-bit index at a time over a valid/ready handshake and clears each bit as it is accepted.
- Sits between per-register or per-unit event sources and the processor control logic, for example writeback/interrupt source identification.

Parameters:
- N, 32, number of request sources; must equal 2**IDX_W.
- IDX_W, 5, width of encoded index.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
- req  input  N  request pulses; bit i high for a cycle sets pending[i].
- flush  input  1  clears all pending bits on the next edge.
- out_ready  input  1  consumer accepts out_idx this cycle.
- out_valid  output  1  at least one pending bit is set.
- out_idx  output  IDX_W  index of the selected pending bit; 0 when out_valid is 0.
- pending  output  N  current pending register, for debug and status.
- pending_cnt  output  IDX_W+1  population count of pending, range 0..32.

Behaviour:
- Reset: pending=0, out_valid=0, out_idx=0, pending_cnt=0. The round-robin pointer ptr (internal, IDX_W bits) is 0.
- State: pending[N-1:0], ptr. out_valid, out_idx and pending_cnt are combinational functions of registered state only. There is no combinational path from req, flush or out_ready to any output.
- Latency: a req pulse in cycle T is visible in pending and out_valid in cycle T+1.
- Selection: out_idx is the lowest index i with pending[i]=1, searched with fixed priority; bit 0 is highest.
- Accept: a handshake occurs when out_valid and out_ready are both high at a rising edge.
  - On a handshake, pending[out_idx] is cleared on that edge.
  - With REQ_ENC_RR_EN defined, ptr is also loaded with out_idx+1 (mod N); 31 wraps to 0.
- Next-state order per edge:
  - pending_next = (pending & ~accept_mask) | req.
  - accept_mask is one-hot at out_idx when a handshake occurs, else 0.
  - A set wins over a clear: req[k]=1 in the same cycle bit k is accepted leaves pending[k]=1, and out_valid stays 1.
- Requests on already-pending bits are merged. No counting and no overflow: each bit is a sticky flag.
- out_ready while out_valid=0: ignored; no state change.
- out_idx must stay stable while out_valid=1 and out_ready=0, unless a new req sets a higher-priority bit.
  - The consumer must tolerate this.
  - In RR mode, "higher-priority" means closer to ptr in circular order.
- flush: pending_next = req. Flush clears old state, but requests arriving in the same cycle are kept. A handshake in the same cycle is irrelevant. ptr is unchanged.
- reset has priority over flush, req and handshake. Reset mid-stream discards all pending bits and returns ptr to 0.
- pending_cnt is the population count of pending, 0 to 32 inclusive. The value 32 requires width IDX_W+1.
- Full (all 32 pending): out_valid=1; out_idx=0 in fixed mode, ptr in RR mode. No back-pressure on req.

Optional Feature:
- Macro: REQ_ENC_RR_EN.
- Defined:
  - Round-robin selection: out_idx is the first set bit at or after ptr, scanning ptr, ptr+1, ... with wrap to 0.
  - ptr updates on each handshake as described above.
- Undefined:
  - Fixed priority, lowest index wins.
  - ptr logic is removed and no ptr register exists.
- Both builds must be identical in reset values, latency, flush behaviour and set-wins-over-clear behaviour.

Test Plan:
- Reset then idle, req=0, out_ready=1, 10 cycles -> out_valid=0, out_idx=0, pending_cnt=0 throughout.
- Pulse req=32'h8000_0011 one cycle, out_ready=0 -> next cycle pending=32'h8000_0011, pending_cnt=3, out_idx=0. Then out_ready=1 for 3 cycles:
  - Fixed build: out_idx sequence 0, 4, 31, then out_valid=0.
- RR build: pending=32'h0000_0009 with ptr=0 -> accepts idx 0, ptr=1, then idx 3. Hold req[0]=1 every cycle with out_ready=1 -> after the idx 0 accept, idx 3 is selected before idx 0 is re-served, proving no starvation. Pointer wrap: accept idx 31 -> ptr=0.
- Set-vs-clear: pending=32'h0000_0004, out_ready=1 and req=32'h0000_0004 in the same cycle -> next cycle pending=32'h0000_0004, out_valid=1, pending_cnt=1.
- Full and flush: pulse req=32'hFFFF_FFFF -> pending_cnt=32, out_valid=1. Then flush=1 with req=32'h0000_0100 -> next cycle pending=32'h0000_0100, pending_cnt=1, out_idx=8.
- Reset mid-operation: pending=32'h00F0_0000, assert reset one cycle during a handshake -> next cycle pending=0, out_valid=0. In the RR build, a following req=32'h0000_0003 yields out_idx=0, confirming ptr returned to 0.
